fifo_enq_arbiter: RTL

//   Shares the single enqueue port of one fifo between N_REQ requesters using round-robin priority.

---
 rtl/fifo_arb_pkg.sv | 7 +
 rtl/rr_priority_picker.sv | 33 +++
 rtl/fifo_enq_arbiter.sv | 74 +++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared payload/counter types for the fifo enqueue arbiter
package fifo_arb_pkg;
  localparam int CNT_WIDTH = 32;
  localparam int DEF_ENTRY_WIDTH = 32;
  typedef logic [DEF_ENTRY_WIDTH-1:0] entry_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first valid requester at or after rr_ptr, as one-hot grant and index
module rr_priority_picker #(
  parameter int N_REQ = 4,
  localparam int IDX_WIDTH = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  output logic [N_REQ-1:0]     grant,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 any
);
  int j;
  logic [IDX_WIDTH-1:0] jj;
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    j = 0;
    jj = '0;
    // descending scan so the closest requester to rr_ptr is written last and wins
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      j = (j >= N_REQ) ? j - N_REQ : j;
      jj = IDX_WIDTH'(j);
      if (req_valid[jj]) begin
        grant = '0;
        grant[jj] = 1'b1;
        idx = jj;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter: round-robin share of one fifo enqueue port; FIFO_ARB_PERF_CTR_EN adds grant counters
module fifo_enq_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ENTRY_WIDTH = $bits(entry_t),
  localparam int IDX_WIDTH = $clog2(N_REQ)
) (
  input  logic                                clk,
  input  logic                                rst_aL,
  input  logic [N_REQ-1:0]                    req_valid,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic [N_REQ-1:0][ENTRY_WIDTH-1:0]   req_data,
  input  logic                                flush,
  input  logic                                fifo_enq_ready,
  output logic                                fifo_enq_valid,
  output logic [ENTRY_WIDTH-1:0]              fifo_enq_data,
  output logic [IDX_WIDTH-1:0]                fifo_enq_src
`ifdef FIFO_ARB_PERF_CTR_EN
  ,
  output logic [N_REQ-1:0][CNT_WIDTH-1:0]     grant_cnt
`endif
);
  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [IDX_WIDTH-1:0] win_idx;
  logic [N_REQ-1:0]     grant;
  logic                 win_any;
  logic                 can_accept;
  logic                 xfer;

  rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .idx       (win_idx),
    .any       (win_any)
  );

  assign can_accept = !fifo_enq_valid || fifo_enq_ready;
  assign req_ready = (rst_aL && can_accept && !flush) ? grant : '0;
  assign xfer = win_any && |req_ready;

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      fifo_enq_valid <= 1'b0;
      fifo_enq_data <= '0;
      fifo_enq_src <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      fifo_enq_valid <= 1'b0;
    end else if (xfer) begin
      fifo_enq_valid <= 1'b1;
      fifo_enq_data <= req_data[win_idx];
      fifo_enq_src <= win_idx;
      rr_ptr <= (win_idx == IDX_WIDTH'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (can_accept) begin
      fifo_enq_valid <= 1'b0;
    end
  end

`ifdef FIFO_ARB_PERF_CTR_EN
  logic [N_REQ-1:0][CNT_WIDTH-1:0] cnt;
  assign grant_cnt = cnt;
  // saturating: once all-ones the counter stays there
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL)
      cnt <= '0;
    else
      for (int i = 0; i < N_REQ; i++)
        if (req_ready[i] && req_valid[i] && cnt[i] != '1)
          cnt[i] <= cnt[i] + 1'b1;
  end
`endif
endmodule
